// File: rtl/dot_product_engine.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_engine
// Purpose  : Multi-lane dot product of two captured N-element vectors with
//            signed/unsigned operands, optional accumulation onto the previous
//            result and saturating arithmetic with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_engine #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic                    accumulate,
  input  logic [N*DATA_WIDTH-1:0] inp1,
  input  logic [N*DATA_WIDTH-1:0] inp2,
  output logic                    busy,
  output logic [ACC_WIDTH-1:0]    sum,
  output logic                    product_done,
  output logic                    overflow
);

  localparam int c_vec_w  = N * DATA_WIDTH;
  localparam int c_prod_w = 2 * DATA_WIDTH;
  // Lane partial sum has headroom for LANES full products plus a sign bit.
  localparam int c_part_w = ACC_WIDTH + $clog2(LANES) + 1;
  // One extra bit so accumulator + partial sum can never wrap before clipping.
  localparam int c_ext_w  = c_part_w + 1;
  localparam int c_idx_w  = $clog2(N + 1);
  localparam int c_shift  = LANES * DATA_WIDTH;

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N - LANES);
  localparam logic [c_idx_w-1:0] c_step     = c_idx_w'(LANES);

  localparam logic signed [c_ext_w-1:0] c_smax =
    {{(c_ext_w-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [c_ext_w-1:0] c_smin =
    {{(c_ext_w-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [c_ext_w-1:0] c_umax =
    {{(c_ext_w-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [c_vec_w-1:0]     r_a;
  logic [c_vec_w-1:0]     r_b;
  logic                   r_signed;
  logic [c_idx_w-1:0]     r_idx;
  logic [ACC_WIDTH-1:0]   r_sum;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ovf;

  logic [DATA_WIDTH-1:0]        w_ea;
  logic [DATA_WIDTH-1:0]        w_eb;
  logic [c_prod_w-1:0]          w_prod_s;
  logic [c_prod_w-1:0]          w_prod_u;
  logic [c_part_w-1:0]          w_lane;
  logic [c_part_w-1:0]          w_partial;
  logic signed [c_ext_w-1:0]    w_acc_ext;
  logic signed [c_ext_w-1:0]    w_total;
  logic [ACC_WIDTH-1:0]         w_next;
  logic                         w_clip;

  // Lane products and their sum; operands are shifted down each RUN cycle so
  // the current elements always sit in the lowest LANES slots.
  always_comb begin
    w_ea      = '0;
    w_eb      = '0;
    w_prod_s  = '0;
    w_prod_u  = '0;
    w_lane    = '0;
    w_partial = '0;
    for (int l = 0; l < LANES; l++) begin
      w_ea = r_a[l*DATA_WIDTH +: DATA_WIDTH];
      w_eb = r_b[l*DATA_WIDTH +: DATA_WIDTH];
      // Low 2*DW bits of a product of sign-extended operands equal the signed product.
      w_prod_s = {{DATA_WIDTH{w_ea[DATA_WIDTH-1]}}, w_ea} *
                 {{DATA_WIDTH{w_eb[DATA_WIDTH-1]}}, w_eb};
      w_prod_u = {{DATA_WIDTH{1'b0}}, w_ea} * {{DATA_WIDTH{1'b0}}, w_eb};
      w_lane   = r_signed ? {{(c_part_w-c_prod_w){w_prod_s[c_prod_w-1]}}, w_prod_s}
                          : {{(c_part_w-c_prod_w){1'b0}}, w_prod_u};
      w_partial = w_partial + w_lane;
    end
  end

  // Accumulator update with clipping to the signed or unsigned ACC_WIDTH range.
  always_comb begin
    w_acc_ext = r_signed ? {{(c_ext_w-ACC_WIDTH){r_sum[ACC_WIDTH-1]}}, r_sum}
                         : {{(c_ext_w-ACC_WIDTH){1'b0}}, r_sum};
    w_total   = w_acc_ext + {w_partial[c_part_w-1], w_partial};
    w_next    = w_total[ACC_WIDTH-1:0];
    w_clip    = 1'b0;
    if (r_signed) begin
      if (w_total > c_smax) begin
        w_next = c_smax[ACC_WIDTH-1:0];
        w_clip = 1'b1;
      end else if (w_total < c_smin) begin
        w_next = c_smin[ACC_WIDTH-1:0];
        w_clip = 1'b1;
      end
    end else begin
      if (w_total[c_ext_w-1]) begin
        w_next = '0;
        w_clip = 1'b1;
      end else if (w_total > c_umax) begin
        w_next = c_umax[ACC_WIDTH-1:0];
        w_clip = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs; operands are captured only on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_sum    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= inp1;
            r_b      <= inp2;
            r_signed <= signed_mode;
            r_sum    <= accumulate ? r_sum : '0;
            r_ovf    <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum <= w_next;
          if (w_clip) begin
            r_ovf <= 1'b1;
          end
          r_a   <= r_a >> c_shift;
          r_b   <= r_b >> c_shift;
          r_idx <= r_idx + c_step;
          if (r_idx == c_last_idx) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign sum          = r_sum;
  assign product_done = r_done;
  assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_engine
// Purpose  : Directed self-checking bench for dot_product_engine; four
//            instances cover the base, 16-bit saturating, LANES=1 and LANES=4
//            configurations, all driven from the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic        accumulate;
  logic [31:0] inp1;
  logic [31:0] inp2;

  logic [3:0]  busy_v;
  logic [3:0]  pd_v;
  logic [3:0]  ovf_v;
  logic [31:0] sum_main;
  logic [15:0] sum_sat;
  logic [31:0] sum_l1;
  logic [31:0] sum_l4;

  int          checks;
  int          errors;
  int          first_pd [4];
  int          cnt_pd   [4];
  int          busy_cnt [4];
  logic [31:0] sum_pd   [4];
  logic        ovf_pd   [4];

  localparam logic [31:0] c_a1 = 32'h03020100;  // {0,1,2,3}
  localparam logic [31:0] c_b1 = 32'h07060504;  // {4,5,6,7}

  dot_product_engine #(.N(4), .DATA_WIDTH(8), .LANES(2), .ACC_WIDTH(32)) u_main (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .accumulate(accumulate), .inp1(inp1), .inp2(inp2), .busy(busy_v[0]),
    .sum(sum_main), .product_done(pd_v[0]), .overflow(ovf_v[0]));

  dot_product_engine #(.N(4), .DATA_WIDTH(8), .LANES(2), .ACC_WIDTH(16)) u_sat (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .accumulate(accumulate), .inp1(inp1), .inp2(inp2), .busy(busy_v[1]),
    .sum(sum_sat), .product_done(pd_v[1]), .overflow(ovf_v[1]));

  dot_product_engine #(.N(4), .DATA_WIDTH(8), .LANES(1), .ACC_WIDTH(32)) u_l1 (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .accumulate(accumulate), .inp1(inp1), .inp2(inp2), .busy(busy_v[2]),
    .sum(sum_l1), .product_done(pd_v[2]), .overflow(ovf_v[2]));

  dot_product_engine #(.N(4), .DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(32)) u_l4 (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .accumulate(accumulate), .inp1(inp1), .inp2(inp2), .busy(busy_v[3]),
    .sum(sum_l4), .product_done(pd_v[3]), .overflow(ovf_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_sum(input int d);
    case (d)
      0:       return sum_main;
      1:       return {16'd0, sum_sat};
      2:       return sum_l2_sel();
      default: return sum_l4;
    endcase
  endfunction

  function automatic logic [31:0] sum_l2_sel();
    return sum_l1;
  endfunction

  // Called at a falling edge: present operands with start high for one rising edge (E0).
  task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                          input logic sm, input logic acc);
    inp1        = a;
    inp2        = b;
    signed_mode = sm;
    accumulate  = acc;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // Watch maxc falling edges (cycle 1 = first falling edge after E0); optionally
  // pulse start at cycles rs1/rs2. Records first product_done cycle, sum there.
  task automatic observe(input int maxc, input int rs1, input int rs2);
    for (int d = 0; d < 4; d++) begin
      first_pd[d] = 0; cnt_pd[d] = 0; busy_cnt[d] = 0;
      sum_pd[d] = '0; ovf_pd[d] = 1'b0;
    end
    for (int c = 1; c <= maxc; c++) begin
      for (int d = 0; d < 4; d++) begin
        if (busy_v[d]) busy_cnt[d]++;
        if (pd_v[d]) begin
          cnt_pd[d]++;
          if (first_pd[d] == 0) begin
            first_pd[d] = c;
            sum_pd[d]   = get_sum(d);
            ovf_pd[d]   = ovf_v[d];
          end
        end
      end
      start = (c == rs1) || (c == rs2);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_v[0]); end
    checks++; if (sum_main !== 32'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum_main); end
    checks++; if (pd_v[0] !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", pd_v[0]); end
    checks++; if (ovf_v[0] !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_v[0]); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_start(c_a1, c_b1, 1'b0, 1'b0);
    observe(8, 0, 0);
    checks++; if (first_pd[0] !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", first_pd[0]); end
    checks++; if (cnt_pd[0] !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", cnt_pd[0]); end
    checks++; if (busy_cnt[0] !== 2) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 2", busy_cnt[0]); end
    checks++; if (sum_pd[0] !== 32'd38) begin errors++; $display("FAIL basic_sum: got %0d expected 38", sum_pd[0]); end
    checks++; if (ovf_pd[0] !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf_pd[0]); end
  endtask

  task automatic test_signed();
    do_start(32'h0403FEFF, 32'h01010101, 1'b1, 1'b0);
    observe(8, 0, 0);
    checks++; if (sum_pd[0] !== 32'd4) begin errors++; $display("FAIL signed_sum: got %0d expected 4", sum_pd[0]); end
    do_start(32'h0403FEFF, 32'h01010101, 1'b0, 1'b0);
    observe(8, 0, 0);
    checks++; if (sum_pd[0] !== 32'd516) begin errors++; $display("FAIL unsigned_sum: got %0d expected 516", sum_pd[0]); end
    do_start(32'h0403FEFF, 32'hFF010101, 1'b1, 1'b0);
    observe(8, 0, 0);
    checks++; if (sum_pd[0] !== 32'hFFFFFFFC) begin errors++; $display("FAIL signed_negative: got %h expected fffffffc", sum_pd[0]); end
  endtask

  task automatic test_accumulate();
    do_start(c_a1, c_b1, 1'b0, 1'b0);
    observe(8, 0, 0);
    checks++; if (sum_pd[0] !== 32'd38) begin errors++; $display("FAIL acc_first: got %0d expected 38", sum_pd[0]); end
    do_start(c_a1, c_b1, 1'b0, 1'b1);
    observe(8, 0, 0);
    checks++; if (sum_pd[0] !== 32'd76) begin errors++; $display("FAIL acc_second: got %0d expected 76", sum_pd[0]); end
    do_start(c_a1, c_b1, 1'b0, 1'b0);
    observe(8, 0, 0);
    checks++; if (sum_pd[0] !== 32'd38) begin errors++; $display("FAIL acc_cleared: got %0d expected 38", sum_pd[0]); end
  endtask

  task automatic test_saturation();
    do_start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    observe(8, 0, 0);
    checks++; if (sum_pd[1] !== 32'h0000FFFF) begin errors++; $display("FAIL sat_unsigned_sum: got %h expected ffff", sum_pd[1]); end
    checks++; if (ovf_pd[1] !== 1'b1) begin errors++; $display("FAIL sat_unsigned_ovf: got %b expected 1", ovf_pd[1]); end
    checks++; if (sum_pd[0] !== 32'd260100) begin errors++; $display("FAIL wide_no_sat_sum: got %0d expected 260100", sum_pd[0]); end
    checks++; if (ovf_pd[0] !== 1'b0) begin errors++; $display("FAIL wide_no_sat_ovf: got %b expected 0", ovf_pd[0]); end
    do_start(32'h80808080, 32'h80808080, 1'b1, 1'b0);
    observe(8, 0, 0);
    checks++; if (sum_pd[1] !== 32'h00007FFF) begin errors++; $display("FAIL sat_signed_sum: got %h expected 7fff", sum_pd[1]); end
    checks++; if (ovf_pd[1] !== 1'b1) begin errors++; $display("FAIL sat_signed_ovf: got %b expected 1", ovf_pd[1]); end
    do_start(c_a1, c_b1, 1'b0, 1'b0);
    observe(8, 0, 0);
    checks++; if (sum_pd[1] !== 32'd38) begin errors++; $display("FAIL sat_clean_sum: got %0d expected 38", sum_pd[1]); end
    checks++; if (ovf_pd[1] !== 1'b0) begin errors++; $display("FAIL sat_clean_ovf: got %b expected 0", ovf_pd[1]); end
  endtask

  task automatic test_robustness();
    do_start(c_a1, c_b1, 1'b0, 1'b0);
    inp1 = 32'hFFFFFFFF;  // changing operands after capture must not matter
    inp2 = 32'hFFFFFFFF;
    observe(8, 1, 3);     // start pulsed in RUN (cycle 1) and in DONE (cycle 3)
    checks++; if (cnt_pd[0] !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", cnt_pd[0]); end
    checks++; if (sum_pd[0] !== 32'd38) begin errors++; $display("FAIL ignore_sum: got %0d expected 38", sum_pd[0]); end
    checks++; if (busy_cnt[0] !== 2) begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected 2", busy_cnt[0]); end
    // Mid-RUN reset: accumulate onto 38 so the intermediate sum is non-zero.
    do_start(c_a1, c_b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (sum_main !== 32'd43) begin errors++; $display("FAIL mid_run_sum: got %0d expected 43", sum_main); end
    reset = 1'b0;
    #1;
    checks++; if (sum_main !== 32'd0) begin errors++; $display("FAIL async_reset_sum: got %0d expected 0", sum_main); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", busy_v[0]); end
    @(negedge clk);
    reset = 1'b1;
    observe(8, 0, 0);
    checks++; if (cnt_pd[0] !== 0) begin errors++; $display("FAIL reset_no_done: got %0d expected 0", cnt_pd[0]); end
    do_start(c_a1, c_b1, 1'b0, 1'b1);
    observe(8, 0, 0);
    checks++; if (sum_pd[0] !== 32'd38) begin errors++; $display("FAIL restart_sum: got %0d expected 38", sum_pd[0]); end
  endtask

  task automatic test_lane_sweep();
    do_start(c_a1, c_b1, 1'b0, 1'b0);
    observe(8, 0, 0);
    checks++; if (first_pd[2] !== 5) begin errors++; $display("FAIL lanes1_latency: got %0d expected 5", first_pd[2]); end
    checks++; if (sum_pd[2] !== 32'd38) begin errors++; $display("FAIL lanes1_sum: got %0d expected 38", sum_pd[2]); end
    checks++; if (busy_cnt[2] !== 4) begin errors++; $display("FAIL lanes1_busy_cycles: got %0d expected 4", busy_cnt[2]); end
    checks++; if (first_pd[3] !== 2) begin errors++; $display("FAIL lanes4_latency: got %0d expected 2", first_pd[3]); end
    checks++; if (sum_pd[3] !== 32'd38) begin errors++; $display("FAIL lanes4_sum: got %0d expected 38", sum_pd[3]); end
    checks++; if (busy_cnt[3] !== 1) begin errors++; $display("FAIL lanes4_busy_cycles: got %0d expected 1", busy_cnt[3]); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    accumulate  = 1'b0;
    inp1        = '0;
    inp2        = '0;
    test_reset();
    test_basic();
    test_signed();
    test_accumulate();
    test_saturation();
    test_robustness();
    test_lane_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
